// File: rtl/serial_adder_pkg.sv
//------------------------------------------------------------------------------
// Module   : serial_adder_pkg
// Brief    : State encoding and default width shared by the serial adder block.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage : serial_adder_pkg

`default_nettype wire

// File: rtl/serial_adder_ctrl_full_adder.sv
//------------------------------------------------------------------------------
// Module   : full_adder
// Brief    : Single-bit full adder, the one-bit datapath of the serial adder.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule : full_adder

`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
//------------------------------------------------------------------------------
// Module   : serial_adder_ctrl
// Brief    : Bit-serial WIDTH-bit adder controller, LSB first, with valid/ready
//            handshakes on operand input and result output.
//            Define SERIAL_ADDER_OVF_EN to add the signed overflow output ovf.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

  logic w_fa_sum;
  logic w_fa_cout;
  logic w_accept;
  logic w_last_step;

  assign w_accept    = (state_q == ST_IDLE) && in_valid;
  assign w_last_step = (state_q == ST_RUN) && (bit_cnt_q == C_LAST_BIT);

  full_adder u_full_adder (
    .a    (op_a_q[0]),
    .b    (op_b_q[0]),
    .cin  (carry_q),
    .sum  (w_fa_sum),
    .cout (w_fa_cout)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)    state_d = ST_RUN;
      ST_RUN:  if (w_last_step) state_d = ST_DONE;
      ST_DONE: if (out_ready)   state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Output decode, purely from registered state
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
  end

  always_comb begin
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    bit_cnt_d = bit_cnt_q;
    if (w_accept) begin
      op_a_d    = a;
      op_b_d    = b;
      sum_d     = '0;
      carry_d   = cin;
      bit_cnt_d = '0;
    end else if (state_q == ST_RUN) begin
      // Sum bits enter at the MSB so bit 0 lands at the LSB after WIDTH steps.
      op_a_d    = {1'b0, op_a_q[WIDTH-1:1]};
      op_b_d    = {1'b0, op_b_q[WIDTH-1:1]};
      sum_d     = {w_fa_sum, sum_q[WIDTH-1:1]};
      carry_d   = w_fa_cout;
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a_q    <= '0;
      op_b_q    <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      bit_cnt_q <= '0;
    end else begin
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign sum  = sum_q;
  assign cout = carry_q;

`ifdef SERIAL_ADDER_OVF_EN
  logic c_msb_in_q, c_msb_in_d;
  logic ovf_q, ovf_d;

  // Overflow is the carry into the MSB differing from the carry out of it.
  always_comb begin
    c_msb_in_d = c_msb_in_q;
    ovf_d      = ovf_q;
    if (w_accept) begin
      c_msb_in_d = 1'b0;
      ovf_d      = 1'b0;
    end else if (w_last_step) begin
      c_msb_in_d = carry_q;
      ovf_d      = carry_q ^ w_fa_cout;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_msb_in_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      c_msb_in_q <= c_msb_in_d;
      ovf_q      <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule : serial_adder_ctrl

`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_serial_adder_ctrl
// Brief    : Directed self-checking bench for serial_adder_ctrl at WIDTH=8.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_adder_ctrl;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  int total = 0;
  int bad   = 0;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_ovf(input string tag, input logic exp);
`ifdef SERIAL_ADDER_OVF_EN
    check(tag, 32'(ovf), 32'(exp));
`endif
  endtask

  // Wait for out_valid with a bound; returns the number of ticks taken.
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 30) begin
      tick();
      n++;
    end
  endtask

  task automatic do_add(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic cv, input logic [7:0] es, input logic ec,
                        input logic eo);
    int n;
    a = av; b = bv; cin = cv; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_valid(n);
    check({tag, "_latency"}, 32'(n), 32'd8);
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    check_ovf({tag, "_ovf"}, eo);
    tick();
    check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_sum_hold"}, 32'(sum), 32'(es));
  endtask

  initial begin
    int n;
    int extra;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check_ovf("rst_ovf", 1'b0);

    do_add("basic",  8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
    do_add("wrap",   8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    do_add("ffffc1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    do_add("ovfpos", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    do_add("ovfneg", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

    // Backpressure: consumer stalled in DONE, plus an ignored in_valid there.
    a = 8'h12; b = 8'h34; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    wait_valid(n);
    check("bp_latency", 32'(n), 32'd8);
    for (int i = 0; i < 5; i++) begin
      a = 8'hEE; b = 8'hEE; in_valid = (i == 2);
      tick();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_sum", 32'(sum), 32'h46);
      check("bp_cout", 32'(cout), 32'd0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    check("bp_release_sum", 32'(sum), 32'h46);

    // Ignored input during RUN.
    a = 8'h35; b = 8'h4A; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    a = 8'h11; b = 8'h11; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid(n);
    check("ign_latency", 32'(n + 3), 32'd8);
    check("ign_sum", 32'(sum), 32'h7F);
    tick();
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid) extra++;
    end
    check("ign_no_second_valid", 32'(extra), 32'd0);
    check("ign_idle", 32'(in_ready), 32'd1);

    // Reset mid-run at bit_cnt=3.
    a = 8'hAA; b = 8'h66; cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mrst_in_ready", 32'(in_ready), 32'd1);
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_sum", 32'(sum), 32'd0);
    check("mrst_cout", 32'(cout), 32'd0);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) extra++;
    end
    check("mrst_no_valid", 32'(extra), 32'd0);
    do_add("post_rst", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_serial_adder_ctrl

`default_nettype wire
